// File: rtl/hamming_pkg.sv
// Shared helpers for the pipelined Hamming codec: position map, widths and
// parameter legality.
package hamming_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CORRECTED,
    ERR_UNCORR
  } err_status_e;

  function automatic bit is_pow2(input int unsigned p);
    return (p != 0) && ((p & (p - 1)) == 0);
  endfunction

  function automatic int unsigned cw_width(input int unsigned data_w, input int unsigned par_w);
    return data_w + par_w;
  endfunction

  function automatic int unsigned tw_width(input int unsigned data_w, input int unsigned par_w,
                                           input int unsigned secded);
    return data_w + par_w + secded;
  endfunction

  function automatic bit par_w_legal(input int unsigned data_w, input int unsigned par_w);
    int unsigned one;
    one = 1;
    return (par_w < 31) && ((one << par_w) >= (data_w + par_w + 1));
  endfunction

  // Data index -> codeword bit (position - 1), skipping power-of-two parity slots.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned n;
    int unsigned pos;
    n   = 0;
    pos = 0;
    for (int unsigned p = 1; p <= idx + 34; p++) begin
      if (!is_pow2(p)) begin
        if (n == idx) pos = p - 1;
        n++;
      end
    end
    return pos;
  endfunction

  // Inverse of data_pos for a non-power-of-two position p (1-based).
  function automatic int unsigned data_index(input int unsigned p);
    return p - 1 - $clog2(p + 1);
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Hamming parity/syndrome generator: bit k is the XOR of every codeword
// position (1-based) whose index has bit k set.
module hamming_parity_gen #(
  parameter int unsigned CW    = 11,
  parameter int unsigned PAR_W = 4
) (
  input  logic [CW-1:0]    cw,
  output logic [PAR_W-1:0] par
);

  always_comb begin
    par = '0;
    for (int unsigned k = 0; k < PAR_W; k++) begin
      for (int unsigned p = 1; p <= CW; p++) begin
        if (((p >> k) & 32'd1) != 0) par[k] = par[k] ^ cw[p-1];
      end
    end
  end

endmodule

// File: rtl/hamming_pipe_codec.sv
// Three-stage Hamming channel model: register input, encode + inject error
// mask, then decode/correct with valid/ready backpressure and error counters.
module hamming_pipe_codec
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 7,
  parameter int unsigned PAR_W  = 4,
  parameter int unsigned SECDED = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic [DATA_W+PAR_W+SECDED-1:0]  in_err_mask,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic [PAR_W-1:0]                out_syndrome,
  output logic                            out_corrected,
  output logic                            out_uncorrectable,
  input  logic                            cnt_clr,
  output logic [CNT_W-1:0]                cnt_corrected,
  output logic [CNT_W-1:0]                cnt_uncorr
);

  localparam int unsigned CW = cw_width(DATA_W, PAR_W);
  localparam int unsigned TW = tw_width(DATA_W, PAR_W, SECDED);
  localparam logic [PAR_W-1:0] CW_SYN = PAR_W'(CW);

  if (!par_w_legal(DATA_W, PAR_W)) begin : g_bad_par
    $error("hamming_pipe_codec: PAR_W too small for DATA_W");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: input capture
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [TW-1:0]     s1_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mask  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_mask  <= in_err_mask;
    end
  end

  // ---------------- S2: encode and inject errors
  logic [CW-1:0]    cw_base;
  logic [CW-1:0]    cw_enc;
  logic [PAR_W-1:0] enc_par;
  logic [TW-1:0]    tx_word;

  for (genvar p = 0; p < CW; p++) begin : g_place
    localparam int unsigned P1 = p + 1;
    if (is_pow2(P1)) begin : g_par
      assign cw_base[p] = 1'b0;
      assign cw_enc[p]  = enc_par[$clog2(P1)];
    end else if (data_index(P1) < DATA_W) begin : g_dat
      assign cw_base[p] = s1_data[data_index(P1)];
      assign cw_enc[p]  = cw_base[p];
    end else begin : g_pad
      assign cw_base[p] = 1'b0;
      assign cw_enc[p]  = 1'b0;
    end
  end

  hamming_parity_gen #(.CW(CW), .PAR_W(PAR_W)) u_enc_par (
    .cw  (cw_base),
    .par (enc_par)
  );

  if (SECDED != 0) begin : g_tx_ded
    assign tx_word = {^cw_enc, cw_enc};
  end else begin : g_tx_sec
    assign tx_word = cw_enc;
  end

  logic          s2_valid;
  logic [TW-1:0] s2_cw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_cw    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_cw    <= tx_word ^ s1_mask;
    end
  end

  // ---------------- S3: syndrome, correction, flags
  logic [CW-1:0]     rx_cw;
  logic [PAR_W-1:0]  syn;
  logic              ov_err;
  logic              flip_en;
  logic [CW-1:0]     flip_mask;
  logic [CW-1:0]     fixed_cw;
  logic [DATA_W-1:0] dec_data;
  err_status_e       status;

  assign rx_cw = s2_cw[CW-1:0];

  hamming_parity_gen #(.CW(CW), .PAR_W(PAR_W)) u_syn (
    .cw  (rx_cw),
    .par (syn)
  );

  if (SECDED != 0) begin : g_ov_ded
    assign ov_err = ^s2_cw;
  end else begin : g_ov_sec
    assign ov_err = 1'b0;
  end

  // Overall-parity mismatch marks an odd error count; syndrome 0 then points at the overall bit.
  always_comb begin
    status  = ERR_NONE;
    flip_en = 1'b0;
    if (ov_err) begin
      if (syn > CW_SYN) begin
        status = ERR_UNCORR;
      end else begin
        status  = ERR_CORRECTED;
        flip_en = (syn != '0);
      end
    end else if (syn != '0) begin
      if ((SECDED == 0) && (syn <= CW_SYN)) begin
        status  = ERR_CORRECTED;
        flip_en = 1'b1;
      end else begin
        status = ERR_UNCORR;
      end
    end
  end

  for (genvar p = 0; p < CW; p++) begin : g_flip
    assign flip_mask[p] = flip_en && (syn == PAR_W'(p + 1));
  end

  assign fixed_cw = rx_cw ^ flip_mask;

  for (genvar i = 0; i < DATA_W; i++) begin : g_extract
    assign dec_data[i] = fixed_cw[data_pos(i)];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (adv) begin
      out_valid         <= s2_valid;
      out_data          <= dec_data;
      out_syndrome      <= syn;
      out_corrected     <= (status == ERR_CORRECTED);
      out_uncorrectable <= (status == ERR_UNCORR);
    end
  end

  // ---------------- error counters
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_corrected <= '0;
      cnt_uncorr    <= '0;
    end else if (cnt_clr) begin
      cnt_corrected <= '0;
      cnt_uncorr    <= '0;
    end else if (out_xfer) begin
      if (out_corrected && (cnt_corrected != '1))
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (out_uncorrectable && (cnt_uncorr != '1))
        cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_pipe_codec.sv
// Bench for hamming_pipe_codec: SEC, SECDED and 2-bit-counter instances share
// stimulus; a position-XOR reference model feeds a scoreboard.
module tb_hamming_pipe_codec;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [6:0]  in_data = '0;
  logic [10:0] m11 = '0;
  logic [11:0] m12 = '0;

  always #5 clk = ~clk;

  logic        s_in_ready, s_out_valid, s_cor, s_unc;
  logic [6:0]  s_out_data;
  logic [3:0]  s_syn;
  logic [15:0] s_cc, s_cu;
  logic        d_in_ready, d_out_valid, d_cor, d_unc;
  logic [6:0]  d_out_data;
  logic [3:0]  d_syn;
  logic [15:0] d_cc, d_cu;
  logic        c_in_ready, c_out_valid, c_cor, c_unc;
  logic [6:0]  c_out_data;
  logic [3:0]  c_syn;
  logic [1:0]  c_cc, c_cu;

  hamming_pipe_codec #(.DATA_W(7), .PAR_W(4), .SECDED(0), .CNT_W(16)) u_sec (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_err_mask(m11), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_syndrome(s_syn), .out_corrected(s_cor),
    .out_uncorrectable(s_unc), .cnt_clr(cnt_clr), .cnt_corrected(s_cc), .cnt_uncorr(s_cu));

  hamming_pipe_codec #(.DATA_W(7), .PAR_W(4), .SECDED(1), .CNT_W(16)) u_ded (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_data(in_data), .in_err_mask(m12), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_data(d_out_data), .out_syndrome(d_syn), .out_corrected(d_cor),
    .out_uncorrectable(d_unc), .cnt_clr(cnt_clr), .cnt_corrected(d_cc), .cnt_uncorr(d_cu));

  hamming_pipe_codec #(.DATA_W(7), .PAR_W(4), .SECDED(0), .CNT_W(2)) u_c2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_err_mask(m11), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_syndrome(c_syn), .out_corrected(c_cor),
    .out_uncorrectable(c_unc), .cnt_clr(cnt_clr), .cnt_corrected(c_cc), .cnt_uncorr(c_cu));

  typedef struct packed {
    logic [6:0] data;
    logic [3:0] syn;
    logic       cor;
    logic       unc;
  } res_t;

  typedef struct packed {
    res_t s;
    res_t d;
  } pair_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Parity chosen so the XOR of the positions of all set bits is zero.
  function automatic logic [11:0] enc_model(input bit ded, input logic [6:0] d);
    logic [11:0] cw;
    int di;
    int syn;
    cw = '0;
    di = 0;
    syn = 0;
    for (int p = 1; p <= 11; p++)
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[di];
        di++;
      end
    for (int p = 1; p <= 11; p++) if (cw[p-1]) syn ^= p;
    for (int k = 0; k < 4; k++) if (syn[k]) cw[(1 << k) - 1] = 1'b1;
    if (ded) cw[11] = ^cw[10:0];
    return cw;
  endfunction

  function automatic res_t dec_model(input bit ded, input logic [6:0] d, input logic [11:0] mask);
    logic [11:0] cw;
    int syn;
    int di;
    bit op;
    res_t r;
    cw = enc_model(ded, d) ^ (ded ? mask : {1'b0, mask[10:0]});
    syn = 0;
    for (int p = 1; p <= 11; p++) if (cw[p-1]) syn ^= p;
    op = ded ? ^cw : 1'b0;
    r = '0;
    if (!ded) begin
      if (syn != 0) begin
        if (syn <= 11) begin r.cor = 1'b1; cw[syn-1] = ~cw[syn-1]; end
        else r.unc = 1'b1;
      end
    end else if (op) begin
      if (syn == 0) r.cor = 1'b1;
      else if (syn <= 11) begin r.cor = 1'b1; cw[syn-1] = ~cw[syn-1]; end
      else r.unc = 1'b1;
    end else if (syn != 0) begin
      r.unc = 1'b1;
    end
    r.syn = syn[3:0];
    di = 0;
    for (int p = 1; p <= 11; p++)
      if ((p & (p - 1)) != 0) begin
        r.data[di] = cw[p-1];
        di++;
      end
    return r;
  endfunction

  res_t cur_s, cur_d, cur_c, prev_s, prev_d;
  assign cur_s = {s_out_data, s_syn, s_cor, s_unc};
  assign cur_d = {d_out_data, d_syn, d_cor, d_unc};
  assign cur_c = {c_out_data, c_syn, c_cor, c_unc};

  pair_t sb[$];
  int out_xfers = 0;
  bit prev_stall = 1'b0;
  logic [15:0] e_scc = '0, e_scu = '0, e_dcc = '0, e_dcu = '0;
  logic [1:0]  e_ccc = '0, e_ccu = '0;

  always @(negedge clk) begin
    pair_t e;
    bit xfer;
    if (!reset_n) begin
      sb.delete();
      prev_stall = 1'b0;
      e_scc = '0; e_scu = '0; e_dcc = '0; e_dcu = '0; e_ccc = '0; e_ccu = '0;
    end else begin
      chk("in_ready", {s_in_ready, d_in_ready, c_in_ready}, {3{!s_out_valid || out_ready}});
      chk("valid_align", {d_out_valid, c_out_valid}, {2{s_out_valid}});
      if (prev_stall) begin
        chk("stall_hold_sec", cur_s, prev_s);
        chk("stall_hold_ded", cur_d, prev_d);
      end
      chk("cnt_sec", {s_cc, s_cu}, {e_scc, e_scu});
      chk("cnt_ded", {d_cc, d_cu}, {e_dcc, e_dcu});
      chk("cnt_c2", {c_cc, c_cu}, {e_ccc, e_ccu});
      if (in_valid && s_in_ready)
        sb.push_back({dec_model(1'b0, in_data, {1'b0, m11}), dec_model(1'b1, in_data, m12)});
      xfer = 1'b0;
      if (s_out_valid && out_ready) begin
        out_xfers++;
        if (sb.size() == 0) begin
          chk("unexpected_out", s_out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          xfer = 1'b1;
          chk("sec_out", cur_s, e.s);
          chk("ded_out", cur_d, e.d);
          chk("c2_out", cur_c, e.s);
        end
      end
      if (cnt_clr) begin
        e_scc = '0; e_scu = '0; e_dcc = '0; e_dcu = '0; e_ccc = '0; e_ccu = '0;
      end else if (xfer) begin
        if (e.s.cor) begin
          e_scc = e_scc + 16'd1;
          if (e_ccc != 2'b11) e_ccc = e_ccc + 2'd1;
        end
        if (e.s.unc) begin
          e_scu = e_scu + 16'd1;
          if (e_ccu != 2'b11) e_ccu = e_ccu + 2'd1;
        end
        if (e.d.cor) e_dcc = e_dcc + 16'd1;
        if (e.d.unc) e_dcu = e_dcu + 16'd1;
      end
      prev_stall = s_out_valid && !out_ready;
      prev_s = cur_s;
      prev_d = cur_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [6:0] d, input logic [10:0] a, input logic [11:0] b);
    in_valid = 1'b1;
    in_data  = d;
    m11      = a;
    m12      = b;
    tick();
    in_valid = 1'b0;
    m11      = '0;
    m12      = '0;
  endtask

  task automatic directed(input string name, input bit use_ded, input logic [6:0] d,
                          input logic [10:0] a, input logic [11:0] b,
                          input logic [6:0] x_data, input logic [3:0] x_syn,
                          input logic x_cor, input logic x_unc);
    int lat;
    send1(d, a, b);
    lat = 0;
    repeat (20) begin
      @(negedge clk);
      lat++;
      if (s_out_valid) break;
    end
    chk({name, "_latency"}, lat, 3);
    if (use_ded) chk(name, cur_d, {x_data, x_syn, x_cor, x_unc});
    else         chk(name, cur_s, {x_data, x_syn, x_cor, x_unc});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] words [10];
    int idx, cyc, base, seen, low_rdy;
    bit acc;

    chk("model_enc_55", enc_model(1'b0, 7'h55), 12'h52F);
    chk("model_enc_55_ded", enc_model(1'b1, 7'h55), 12'hD2F);
    chk("model_miscorrect", dec_model(1'b0, 7'h55, 12'h003), {7'h54, 4'h3, 1'b1, 1'b0});

    #12;
    chk("reset_state", {s_out_valid, d_out_valid, c_out_valid, s_cc, s_cu, c_cc}, '0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick();

    // Test 1: reset with three words in flight
    send1(7'h12, 11'h004, 12'h004);
    send1(7'h34, 11'h004, 12'h004);
    repeat (5) tick();
    chk("pre_reset_cnt", {s_cc, d_cc}, {16'd2, 16'd2});
    in_valid = 1'b1;
    m11 = 11'h100;
    m12 = 12'h100;
    for (int i = 1; i <= 3; i++) begin
      in_data = 7'(i);
      tick();
    end
    in_valid = 1'b0;
    m11 = '0;
    m12 = '0;
    #1 reset_n = 1'b0;
    #1 chk("reset_mid_traffic", {s_out_valid, d_out_valid, c_out_valid, s_cc, d_cc, c_cc}, '0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_out_valid) seen++;
    end
    chk("no_stale_words", seen, 0);
    tick();

    // Tests 2-5: directed single words
    directed("t2_clean", 1'b0, 7'h55, 11'h000, 12'h000, 7'h55, 4'h0, 1'b0, 1'b0);
    directed("t3_single", 1'b0, 7'h55, 11'h100, 12'h000, 7'h55, 4'h9, 1'b1, 1'b0);
    chk("t3_cnt_corrected", s_cc, 16'd1);
    directed("t4_miscorrect", 1'b0, 7'h55, 11'h003, 12'h000, 7'h54, 4'h3, 1'b1, 1'b0);
    directed("t4_uncorr", 1'b0, 7'h55, 11'h088, 12'h000, 7'h55, 4'hC, 1'b0, 1'b1);
    directed("t5_ded_double", 1'b1, 7'h55, 11'h000, 12'h003, 7'h55, 4'h3, 1'b0, 1'b1);
    directed("t5_ded_opar", 1'b1, 7'h55, 11'h000, 12'h800, 7'h55, 4'h0, 1'b1, 1'b0);

    // Test 6: 10-word stream with a 4-cycle output stall
    for (int i = 0; i < 10; i++) words[i] = 7'($urandom_range(0, 127));
    base = out_xfers;
    idx = 0;
    cyc = 0;
    low_rdy = 0;
    in_valid = 1'b1;
    in_data = words[0];
    while ((idx < 10) && (cyc < 100)) begin
      out_ready = !((cyc >= 4) && (cyc < 8));
      @(negedge clk);
      acc = in_valid && s_in_ready;
      if (!s_in_ready) low_rdy++;
      tick();
      cyc++;
      if (acc) idx++;
      if (idx < 10) in_data = words[idx];
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("t6_words_out", out_xfers - base, 10);
    chk("t6_in_ready_low", low_rdy, 4);

    // Test 7: saturation of the 2-bit counter, clear coincident with transfer
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t7_clear", {s_cc, s_cu, c_cc, c_cu}, '0);
    in_valid = 1'b1;
    m11 = 11'h100;
    m12 = 12'h100;
    for (int i = 0; i < 5; i++) begin
      in_data = 7'(8 * i + 3);
      tick();
    end
    in_valid = 1'b0;
    m11 = '0;
    m12 = '0;
    repeat (6) tick();
    chk("t7_sat_c2", c_cc, 2'd3);
    chk("t7_cnt_sec", {s_cc, d_cc}, {16'd5, 16'd5});
    send1(7'h2A, 11'h100, 12'h100);
    tick();
    tick();
    chk("t7_out_valid", c_out_valid, 1'b1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t7_clr_wins", {c_cc, s_cc, d_cc}, '0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
